// File: rtl/divn_counter.sv
// Purpose: programmable divide-by-N up/down counter with cascadable enables, load/clear, one-shot mode.
// Latency: count/wrap/done/modulus update one clock after inputs are sampled; tc is combinational.
// Backpressure: none; cet/cep gate counting, and tc feeds the next stage's cet.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       asynchronous active-low reset
//   i_cet       count enable, also gates o_tc
//   i_cep       count enable only
//   i_up_dn     1 = up, 0 = down
//   i_sclr      synchronous clear (highest priority)
//   i_load      synchronous load of min(i_load_val, modulus-1)
//   i_load_val  load value
//   i_mod_we    modulus write strobe (values below 2 are ignored)
//   i_mod_in    new modulus
//   i_one_shot  hold at terminal instead of wrapping
//   o_count     current count
//   o_tc        terminal count (cet && term)
//   o_wrap      registered one-cycle pulse on a terminal event
//   o_done      one-shot completion flag
//   o_modulus   current modulus register
module divn_counter #(
    parameter int SIZE   = 5,
    parameter int LENGTH = 20
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cet,
    input  logic            i_cep,
    input  logic            i_up_dn,
    input  logic            i_sclr,
    input  logic            i_load,
    input  logic [SIZE-1:0] i_load_val,
    input  logic            i_mod_we,
    input  logic [SIZE-1:0] i_mod_in,
    input  logic            i_one_shot,
    output logic [SIZE-1:0] o_count,
    output logic            o_tc,
    output logic            o_wrap,
    output logic            o_done,
    output logic [SIZE-1:0] o_modulus
);

    localparam logic [SIZE-1:0] RST_MOD = LENGTH[SIZE-1:0];

    logic [SIZE-1:0] r_count;
    logic [SIZE-1:0] r_modulus;
    logic            r_wrap;
    logic            r_done;

    logic [SIZE-1:0] w_mod_m1;
    logic            w_en;
    logic            w_term;
    logic [SIZE-1:0] w_load_clip;
    logic            w_mod_ok;

    assign w_mod_m1    = r_modulus - 1'b1;
    assign w_en        = i_cet & i_cep;
    // Up uses >= so a count stranded above a reduced modulus still terminates.
    assign w_term      = i_up_dn ? (r_count >= w_mod_m1) : (r_count == '0);
    assign w_load_clip = (i_load_val > w_mod_m1) ? w_mod_m1 : i_load_val;
    assign w_mod_ok    = i_mod_we & (i_mod_in >= SIZE'(2));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_sclr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_load) begin
            r_count <= w_load_clip;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_en) begin
            if (i_one_shot && r_done) begin
                // Completed one-shot: freeze, no further pulses.
                r_wrap <= 1'b0;
            end else if (!w_term) begin
                r_count <= i_up_dn ? (r_count + 1'b1) : (r_count - 1'b1);
                r_wrap  <= 1'b0;
            end else if (!i_one_shot) begin
                r_count <= i_up_dn ? '0 : w_mod_m1;
                r_wrap  <= 1'b1;
            end else begin
                // First terminal hit in one-shot: hold count, flag done, pulse once.
                r_done <= 1'b1;
                r_wrap <= 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Modulus register is independent of clear/load; the new value only
    // affects count updates from the following cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_modulus <= RST_MOD;
        end else if (w_mod_ok) begin
            r_modulus <= i_mod_in;
        end
    end

    assign o_count   = r_count;
    assign o_tc      = i_cet & w_term;
    assign o_wrap    = r_wrap;
    assign o_done    = r_done;
    assign o_modulus = r_modulus;

endmodule

// File: tb/tb_divn_counter.sv
// Purpose: self-checking bench for divn_counter against an integer reference model.
// Latency: model advances once per clock edge; tc is checked before the edge.
// Backpressure: not applicable.
module tb_divn_counter;

    localparam int SIZE   = 5;
    localparam int LENGTH = 20;

    logic            clk;
    logic            rst;
    logic            cet, cep, up_dn, sclr, load, mod_we, one_shot;
    logic [SIZE-1:0] load_val, mod_in;
    logic [SIZE-1:0] count, modulus;
    logic            tc, wrap, done;

    int n_vec;
    int n_err;

    // Reference model state, plain integers.
    int m_count, m_mod, m_wrap, m_done;

    divn_counter #(.SIZE(SIZE), .LENGTH(LENGTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cet      (cet),
        .i_cep      (cep),
        .i_up_dn    (up_dn),
        .i_sclr     (sclr),
        .i_load     (load),
        .i_load_val (load_val),
        .i_mod_we   (mod_we),
        .i_mod_in   (mod_in),
        .i_one_shot (one_shot),
        .o_count    (count),
        .o_tc       (tc),
        .o_wrap     (wrap),
        .o_done     (done),
        .o_modulus  (modulus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_term(input int up);
        if (up != 0) return (m_count >= m_mod - 1) ? 1 : 0;
        return (m_count == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_count = 0; m_mod = LENGTH; m_wrap = 0; m_done = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},   int'(count),   m_count);
        chk({tag, ".wrap"},    int'(wrap),    m_wrap);
        chk({tag, ".done"},    int'(done),    m_done);
        chk({tag, ".modulus"}, int'(modulus), m_mod);
    endtask

    // One clock: drive inputs, check tc, advance model, clock, check registers.
    task automatic cyc(input string tag, input bit i_cet, input bit i_cep, input bit i_up,
                       input bit i_sc, input bit i_ld, input int i_lv,
                       input bit i_mwe, input int i_mi, input bit i_os);
        int term, en, nxt_mod;
        cet = i_cet; cep = i_cep; up_dn = i_up; sclr = i_sc; load = i_ld;
        load_val = i_lv[SIZE-1:0]; mod_we = i_mwe; mod_in = i_mi[SIZE-1:0]; one_shot = i_os;
        #1;
        term = model_term(int'(i_up));
        chk({tag, ".tc"}, int'(tc), (i_cet && term != 0) ? 1 : 0);
        en = (i_cet && i_cep) ? 1 : 0;
        nxt_mod = (i_mwe && i_mi >= 2) ? i_mi : m_mod;
        if (i_sc) begin
            m_count = 0; m_done = 0; m_wrap = 0;
        end else if (i_ld) begin
            m_count = (i_lv > m_mod - 1) ? m_mod - 1 : i_lv;
            m_done = 0; m_wrap = 0;
        end else if (en != 0) begin
            if (i_os && m_done != 0) begin
                m_wrap = 0;
            end else if (term == 0) begin
                m_count = i_up ? m_count + 1 : m_count - 1;
                m_wrap = 0;
            end else if (!i_os) begin
                m_count = i_up ? 0 : m_mod - 1;
                m_wrap = 1;
            end else begin
                m_done = 1; m_wrap = 1;
            end
        end else begin
            m_wrap = 0;
        end
        m_mod = nxt_mod;
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic run_up(input string tag, input int n, input bit os);
        for (int i = 0; i < n; i++) cyc(tag, 1, 1, 1, 0, 0, 0, 0, 0, os);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; cet = 0; cep = 0; up_dn = 1; sclr = 0; load = 0;
        load_val = '0; mod_we = 0; mod_in = '0; one_shot = 0;
        model_reset();
        #12;
        chk("reset.count",   int'(count),   0);
        chk("reset.modulus", int'(modulus), LENGTH);
        chk("reset.wrap",    int'(wrap),    0);
        chk("reset.done",    int'(done),    0);
        rst = 1'b1;

        // 1: default divide-by-20, 25 clocks.
        run_up("t1", 25, 0);
        chk("t1.end_count", int'(count), 5);

        // 2: reach 19, then cep=0 holds with tc=1, then cet=0 drops tc.
        run_up("t2a", 14, 0);
        chk("t2.at19", int'(count), 19);
        cyc("t2_hold", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t2.hold_wrap", int'(wrap), 0);
        cyc("t2_cet0", 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // 3: modulus 7 written at count=12.
        cyc("t3_ld", 0, 0, 1, 0, 1, 12, 0, 0, 0);
        cyc("t3_mw", 1, 1, 1, 0, 0, 0, 1, 7, 0);
        chk("t3.old_mod", int'(count), 13);
        cyc("t3_strand", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("t3.wrap0", int'(count), 0);
        run_up("t3_run", 10, 0);
        cyc("t3_bad", 0, 0, 1, 0, 0, 0, 1, 1, 0);
        chk("t3.mod_kept", int'(modulus), 7);

        // 4: down counting with modulus 20, load clipping, sclr over load.
        cyc("t4_mw", 0, 0, 0, 0, 0, 0, 1, 20, 0);
        cyc("t4_ld", 0, 0, 0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("t4_dn", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t4.after_wrap", int'(count), 18);
        cyc("t4_clip", 0, 0, 0, 0, 1, 25, 0, 0, 0);
        chk("t4.clip", int'(count), 19);
        cyc("t4_scld", 1, 1, 0, 1, 1, 5, 0, 0, 0);
        chk("t4.sclr_wins", int'(count), 0);

        // 5: one-shot, modulus 5.
        cyc("t5_mw", 0, 0, 1, 1, 0, 0, 1, 5, 1);
        run_up("t5_os", 8, 1);
        chk("t5.hold", int'(count), 4);
        chk("t5.done", int'(done), 1);
        cyc("t5_ld", 0, 0, 1, 0, 1, 2, 0, 0, 1);
        run_up("t5_resume", 2, 1);
        chk("t5.resume", int'(count), 4);

        // 6: async reset mid-count with count=11, modulus=9.
        cyc("t6_mw", 0, 0, 1, 0, 0, 0, 1, 20, 0);
        cyc("t6_ld", 0, 0, 1, 0, 1, 11, 1, 9, 0);
        cyc("t6_en", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("t6.pre_count", int'(count), 11);
        chk("t6.pre_mod", int'(modulus), 9);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("t6.count",   int'(count),   0);
        chk("t6.modulus", int'(modulus), LENGTH);
        chk("t6.done",    int'(done),    0);
        chk("t6.wrap",    int'(wrap),    0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc("rnd",
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 31)),
                ($urandom_range(0, 15) == 0), int'($urandom_range(0, 31)),
                ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
